// File: rtl/rb_stream_ctrl_pkg.sv
// Shared types and defaults for the row-buffer stream controller.
// Imported by the controller top and its wrap counter.
package rb_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;
    localparam int K_ROWS_DEF = 3;

    function automatic int steer_w(input int k_rows);
        return (k_rows - 1 > 1) ? $clog2(k_rows - 1) : 1;
    endfunction

endpackage

// File: rtl/rb_stream_ctrl_wrap_counter.sv
// Modulo (MAX+1) counter with synchronous clear and a wrap strobe.
// Used for the buffer pointer, the column and the row segment.
module rb_stream_ctrl_wrap_counter #(
    parameter int W   = 1,
    parameter int MAX = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en & (cnt == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/rb_stream_ctrl.sv
// Row-buffer controller: FILL, PRIME, RUN, DONE over a valid/ready
// pixel stream, with restart from any state.
module rb_stream_ctrl
    import rb_stream_ctrl_pkg::*;
#(
    parameter  int IMG_W   = IMG_W_DEF,
    parameter  int IMG_H   = IMG_H_DEF,
    parameter  int K_ROWS  = K_ROWS_DEF,
    localparam int DEPTH   = (K_ROWS - 1) * IMG_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(IMG_W * IMG_H + 1),
    localparam int STEER_W = steer_w(K_ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               wr_en,
    output logic [PTR_W-1:0]   wr_addr,
    output logic               rd_en,
    output logic [PTR_W-1:0]   rd_addr,
    output logic [STEER_W-1:0] steer,
    output logic               steer_en,
    output logic               win_valid,
    output logic               busy,
    output logic               complete
);

    localparam int COL_W = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_W * IMG_H - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic               r_win_valid;

    logic               w_fill;
    logic               w_prime;
    logic               w_run;
    logic               w_xfer;
    logic               w_last;
    logic [PTR_W-1:0]   w_ptr;
    logic               w_ptr_wrap;
    logic [COL_W-1:0]   w_col;
    logic               w_col_wrap;
    logic [STEER_W-1:0] w_seg;
    logic               w_unused_seg_wrap;

    assign w_fill  = (r_state == S_FILL);
    assign w_prime = (r_state == S_PRIME);
    assign w_run   = (r_state == S_RUN);
    assign w_xfer  = pix_valid & pix_ready;
    assign w_last  = w_run & w_xfer & (r_pix_cnt == LAST_CNT);

    rb_stream_ctrl_wrap_counter #(.W(PTR_W), .MAX(DEPTH - 1)) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_xfer),
        .clr   (start),
        .cnt   (w_ptr),
        .wrap  (w_ptr_wrap)
    );

    rb_stream_ctrl_wrap_counter #(.W(COL_W), .MAX(IMG_W - 1)) u_col (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_xfer & w_run),
        .clr   (start),
        .cnt   (w_col),
        .wrap  (w_col_wrap)
    );

    // Segment advances once per full image row, replacing a divide by IMG_W.
    rb_stream_ctrl_wrap_counter #(.W(STEER_W), .MAX(K_ROWS - 2)) u_seg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_col_wrap),
        .clr   (start),
        .cnt   (w_seg),
        .wrap  (w_unused_seg_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= w_run & w_xfer;
            if (start) begin
                r_state   <= S_FILL;
                r_pix_cnt <= '0;
            end else begin
                if (w_xfer) begin
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
                unique case (r_state)
                    S_FILL:  if (w_xfer && w_ptr_wrap) r_state <= S_PRIME;
                    S_PRIME: r_state <= S_RUN;
                    S_RUN:   if (w_last) r_state <= S_DONE;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign pix_ready = w_fill | w_run;
    assign wr_en     = w_xfer;
    assign wr_addr   = (w_fill | w_run) ? w_ptr : '0;
    assign rd_en     = w_prime | (w_run & w_xfer);
    assign rd_addr   = (w_prime | w_run) ? w_ptr : '0;
    assign steer     = w_run ? w_seg : '0;
    assign steer_en  = w_run & w_xfer;
    assign win_valid = r_win_valid;
    assign busy      = w_fill | w_prime | w_run;
    assign complete  = (r_state == S_DONE);

endmodule

// File: tb/tb_rb_stream_ctrl.sv
// Directed bench for rb_stream_ctrl: a 4x4/K=3 instance and a
// 5x3/K=2 instance sharing stimulus, outputs selected by sel.
module tb_rb_stream_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic pix_valid;
    bit   sel;

    int n_cmp = 0;
    int n_bad = 0;

    logic       a_ready, a_wr_en, a_rd_en, a_steer, a_steer_en;
    logic       a_win, a_busy, a_complete;
    logic [2:0] a_wr_addr, a_rd_addr;
    logic       b_ready, b_wr_en, b_rd_en, b_steer, b_steer_en;
    logic       b_win, b_busy, b_complete;
    logic [2:0] b_wr_addr, b_rd_addr;

    logic       pix_ready, wr_en, rd_en, steer, steer_en;
    logic       win_valid, busy, complete;
    logic [2:0] wr_addr, rd_addr;
    logic [13:0] all_out;

    always #5 clk = ~clk;

    rb_stream_ctrl #(.IMG_W(4), .IMG_H(4), .K_ROWS(3)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (a_ready),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .rd_en     (a_rd_en),
        .rd_addr   (a_rd_addr),
        .steer     (a_steer),
        .steer_en  (a_steer_en),
        .win_valid (a_win),
        .busy      (a_busy),
        .complete  (a_complete)
    );

    rb_stream_ctrl #(.IMG_W(5), .IMG_H(3), .K_ROWS(2)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (b_ready),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .rd_en     (b_rd_en),
        .rd_addr   (b_rd_addr),
        .steer     (b_steer),
        .steer_en  (b_steer_en),
        .win_valid (b_win),
        .busy      (b_busy),
        .complete  (b_complete)
    );

    assign pix_ready = sel ? b_ready    : a_ready;
    assign wr_en     = sel ? b_wr_en    : a_wr_en;
    assign wr_addr   = sel ? b_wr_addr  : a_wr_addr;
    assign rd_en     = sel ? b_rd_en    : a_rd_en;
    assign rd_addr   = sel ? b_rd_addr  : a_rd_addr;
    assign steer     = sel ? b_steer    : a_steer;
    assign steer_en  = sel ? b_steer_en : a_steer_en;
    assign win_valid = sel ? b_win      : a_win;
    assign busy      = sel ? b_busy     : a_busy;
    assign complete  = sel ? b_complete : a_complete;
    assign all_out   = {pix_ready, wr_en, wr_addr, rd_en, rd_addr,
                        steer, steer_en, win_valid, busy, complete};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: full frame; 1: restart on RUN xfer index 'at'; 2: reset there
    task automatic frame(input int w, input int k, input int h,
                         input bit gappy, input int mode, input int at);
        int  depth;
        int  runlen;
        int  ptr;
        int  col;
        int  seg;
        int  n;
        int  nfill;
        int  ev;
        bit  pv;
        depth  = (k - 1) * w;
        runlen = w * h - depth;
        ptr = 0; col = 0; seg = 0; n = 0; nfill = 0; ev = 0; pv = 1'b1;

        start = 1'b1; pix_valid = 1'b0; #1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_complete", 32'(complete), 0);
        check("start_busy", 32'(busy), 1);
        check("start_wr_addr", 32'(wr_addr), 0);

        while (nfill < depth) begin
            pix_valid = pv; #1;
            check("fill_ready", 32'(pix_ready), 1);
            check("fill_wr_en", 32'(wr_en), 32'(pv));
            check("fill_wr_addr", 32'(wr_addr), ptr);
            check("fill_rd_en", 32'(rd_en), 0);
            check("fill_steer_en", 32'(steer_en), 0);
            @(posedge clk); #1;
            if (pv) begin
                nfill++;
                ptr = (ptr == depth - 1) ? 0 : ptr + 1;
            end
            if (gappy) pv = !pv;
        end

        pix_valid = 1'b1; #1;
        check("prime_ready", 32'(pix_ready), 0);
        check("prime_rd_en", 32'(rd_en), 1);
        check("prime_rd_addr", 32'(rd_addr), 0);
        check("prime_wr_en", 32'(wr_en), 0);
        check("prime_win", 32'(win_valid), 0);
        @(posedge clk); #1;

        while (n < runlen) begin
            pix_valid = pv;
            if (mode == 1 && n == at && pv) start = 1'b1;
            #1;
            check("run_ready", 32'(pix_ready), 1);
            check("run_wr_en", 32'(wr_en), 32'(pv));
            check("run_rd_en", 32'(rd_en), 32'(pv));
            check("run_steer_en", 32'(steer_en), 32'(pv));
            check("run_wr_addr", 32'(wr_addr), ptr);
            check("run_rd_addr", 32'(rd_addr), ptr);
            check("run_steer", 32'(steer), seg);
            check("run_win", 32'(win_valid), ev);
            check("run_complete", 32'(complete), 0);
            if (mode == 2 && n == at) begin
                #2 rst_n = 1'b0;
                #1 check("rst_async_outs", 32'(all_out), 0);
                @(posedge clk); #1;
                check("rst_held_outs", 32'(all_out), 0);
                rst_n = 1'b1; pix_valid = 1'b0;
                @(posedge clk); #1;
                check("rst_idle_ready", 32'(pix_ready), 0);
                check("rst_idle_busy", 32'(busy), 0);
                return;
            end
            @(posedge clk); #1;
            if (start) begin
                start = 1'b0;
                check("restart_busy", 32'(busy), 1);
                check("restart_ready", 32'(pix_ready), 1);
                check("restart_wr_addr", 32'(wr_addr), 0);
                check("restart_complete", 32'(complete), 0);
                check("restart_late_win", 32'(win_valid), 1);
                pix_valid = 1'b0;
                @(posedge clk); #1;
                check("restart_win_gone", 32'(win_valid), 0);
                check("restart_complete2", 32'(complete), 0);
                return;
            end
            ev = pv ? 1 : 0;
            if (pv) begin
                n++;
                ptr = (ptr == depth - 1) ? 0 : ptr + 1;
                if (col == w - 1) begin
                    col = 0;
                    seg = (seg == k - 2) ? 0 : seg + 1;
                end else begin
                    col++;
                end
            end
            if (gappy) pv = !pv;
        end

        pix_valid = 1'b1; #1;
        check("done_complete", 32'(complete), 1);
        check("done_final_win", 32'(win_valid), 1);
        check("done_busy", 32'(busy), 0);
        check("done_ready", 32'(pix_ready), 0);
        check("done_wr_en", 32'(wr_en), 0);
        check("done_rd_en", 32'(rd_en), 0);
        @(posedge clk); #1;
        check("done_win_clear", 32'(win_valid), 0);
        check("done_held", 32'(complete), 1);
        pix_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; sel = 1'b0;
        #1;
        check("reset_outs", 32'(all_out), 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 32'(pix_ready), 0);
        check("idle_complete", 32'(complete), 0);

        frame(4, 3, 4, 1'b0, 0, 0);
        frame(4, 3, 4, 1'b0, 0, 0);
        frame(4, 3, 4, 1'b1, 0, 0);
        frame(4, 3, 4, 1'b0, 1, 4);
        frame(4, 3, 4, 1'b0, 0, 0);
        frame(4, 3, 4, 1'b0, 2, 3);
        frame(4, 3, 4, 1'b0, 0, 0);

        sel = 1'b1;
        frame(5, 2, 3, 1'b0, 0, 0);
        frame(5, 2, 3, 1'b1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
